// File: rtl/bcd_counter_nd_pkg.sv
// Shared definitions for the multi-digit BCD counter.
// Provides the decade digit type, digit limits and the load clamp helper.
// Ports: none (package).
package bcd_counter_nd_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX_DIGIT = 4'd9;
  localparam digit_t BCD_ZERO      = 4'd0;

  // Forces an out-of-range nibble (A-F) to 9 so state never leaves BCD.
  function automatic digit_t clamp_digit(input digit_t d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_counter_nd_if.sv
// Control and status bundle for bcd_counter_nd.
// Latency: n/a (wires only).
// Backpressure: none; the counter accepts a control every cycle.
// Signals: enable/clear/load/load_value/up toward the counter;
//          bcd/at_limit/rollover back from it.
interface bcd_counter_nd_if #(
  parameter int DIGITS = 2
);

  logic                  enable;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  up;
  logic [4*DIGITS-1:0]   bcd;
  logic                  at_limit;
  logic                  rollover;

  modport master (
    output enable, clear, load, load_value, up,
    input  bcd, at_limit, rollover
  );

  modport slave (
    input  enable, clear, load, load_value, up,
    output bcd, at_limit, rollover
  );

endinterface

// File: rtl/bcd_counter_nd_digit.sv
// Single BCD decade: 0-9 up/down with clear and preset.
// Latency: one cycle from any control to digit.
// Backpressure: none; steps whenever step is high.
// Ports: clock, reset (sync, active-high), clear, load, load_digit (already
//        clamped), step, up -> digit, carry_out (9 going up), borrow_out
//        (0 going down).
module bcd_digit
  import bcd_counter_nd_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   clear,
  input  logic   load,
  input  digit_t load_digit,
  input  logic   step,
  input  logic   up,
  output digit_t digit,
  output logic   carry_out,
  output logic   borrow_out
);

  always_ff @(posedge clock) begin
    if (reset) begin
      digit <= BCD_ZERO;
    end else if (clear) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_digit;
    end else if (step) begin
      if (up) begin
        digit <= (digit == BCD_MAX_DIGIT) ? BCD_ZERO : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_ZERO) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
    end
  end

  assign carry_out  = (digit == BCD_MAX_DIGIT) && up;
  assign borrow_out = (digit == BCD_ZERO) && !up;

endmodule

// File: rtl/bcd_counter_nd.sv
// Multi-digit up/down BCD counter with wrap or saturate at the limit.
// Latency: one cycle from any control to bcd/rollover; at_limit is combinational.
// Backpressure: none; one step per enabled cycle.
// Ports: clock, reset (sync, active-high), bus (slave): enable, clear, load,
//        load_value, up in; bcd, at_limit, rollover out.
module bcd_counter_nd
  import bcd_counter_nd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
)
(
  input  logic               clock,
  input  logic               reset,
  bcd_counter_nd_if.slave    bus
);

  digit_t [DIGITS-1:0] digits;
  digit_t [DIGITS-1:0] load_clamped;
  logic   [DIGITS-1:0] carry;
  logic   [DIGITS-1:0] borrow;
  logic   [DIGITS-1:0] lower_done;  // every digit below k sits at its limit
  logic   [DIGITS-1:0] step;
  logic                limit;
  logic                blocked;
  logic                rollover_q;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i] = clamp_digit(bus.load_value[4*i +: 4]);
    end
  end

  // Ripple of "all lower digits at limit"; carry and borrow are already
  // qualified by direction, so one OR covers both count directions.
  always_comb begin
    logic run;
    run        = 1'b1;
    lower_done = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lower_done[i] = run;
      run           = run & (carry[i] | borrow[i]);
    end
    limit = run;
  end

  // Saturate mode freezes every digit at the limit instead of rolling over.
  assign blocked = !WRAP && limit;
  assign step    = (bus.enable && !blocked) ? lower_done : '0;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .clock      (clock),
        .reset      (reset),
        .clear      (bus.clear),
        .load       (bus.load),
        .load_digit (load_clamped[k]),
        .step       (step[k]),
        .up         (bus.up),
        .digit      (digits[k]),
        .carry_out  (carry[k]),
        .borrow_out (borrow[k])
      );
    end
  endgenerate

  // An enabled step taken at the limit is either a wrap or a blocked step;
  // both report a rollover on the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= bus.enable && !bus.clear && !bus.load && limit;
    end
  end

  assign bus.bcd      = digits;
  assign bus.at_limit = limit;
  assign bus.rollover = rollover_q;

endmodule

// File: doc/bcd_counter_nd.md
Name: bcd_counter_nd

Overview:
Parametrised multi-digit synchronous BCD counter, successor to the single-digit 0–9 counter used by the timing path.
- Counts up or down over 0 .. 10^DIGITS−1, with a selectable wrap or saturate mode.
- Supports synchronous clear and parallel preset load.
- Provides a limit flag and a registered rollover pulse for cascading and for timer-expiry detection in the controller.

Parameters:
DIGITS, 2, number of BCD decades (1..8); the count is 4*DIGITS bits wide, digit 0 least significant.
WRAP, 1, 1 = wrap at the limit; 0 = saturate at the limit.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; clears all state.
enable  input  1  count-enable; one step per cycle while high.
clear  input  1  synchronous clear to zero (the error/abort path).
load  input  1  synchronous parallel preset.
load_value  input  4*DIGITS  preset value, packed BCD.
up  input  1  direction: 1 = increment, 0 = decrement.
bcd  output  4*DIGITS  current count, packed BCD, registered.
at_limit  output  1  combinational; high when bcd equals the limit for the current direction (all 9s if up=1, all 0s if up=0).
rollover  output  1  registered one-cycle pulse following a wrap (WRAP=1) or a blocked step at the limit (WRAP=0).

Behaviour:
- Reset values: bcd = 0, rollover = 0. Everything else follows from these.
- Per-cycle priority: reset > clear > load > enable > hold.
- clear: bcd ← 0 next edge; rollover ← 0.
- load:
  - bcd ← load_value next edge; rollover ← 0.
  - Any load digit > 9 is clamped to 9 per digit (e.g. 0xA3 → 0x93).
- enable=1, up=1:
  - Digit 0 increments. Digit k increments only when all lower digits are 9; a digit at 9 with carry-in becomes 0.
  - At all 9s: WRAP=1 → bcd ← 0 and rollover ← 1; WRAP=0 → bcd holds and rollover ← 1.
- enable=1, up=0:
  - Digit 0 decrements. Digit k decrements only when all lower digits are 0; a digit at 0 with borrow-in becomes 9.
  - At all 0s: WRAP=1 → bcd ← all 9s and rollover ← 1; WRAP=0 → bcd holds and rollover ← 1.
- enable=0 (no clear/load): bcd holds; rollover ← 0.
- rollover is high for exactly the one cycle after the triggering edge. Under sustained saturation it stays high on every enabled cycle at the limit.
- Latency: one cycle from any control input to bcd.
- at_limit tracks the current up value combinationally; a direction change takes effect in the same cycle.
- Changing direction mid-count is legal; the next step uses the new direction, with no extra delay.
- Internal state is held in BCD-valid form; no illegal digit (A–F) is ever reachable.
- reset asserted during load/clear/enable: reset wins, and counting resumes from 0 on the first cycle after reset deasserts.

Decomposition:
- Shared package: BCD_MAX_DIGIT = 4'd9, BCD_ZERO = 4'd0, and a digit typedef (4-bit).
- One natural sub-module, bcd_digit: a single decade with clock, reset, clear, load, load_digit, step, up; outputs digit, carry_out (digit==9 & up) and borrow_out (digit==0 & !up).
- The top instantiates DIGITS bcd_digit cells in a generate loop. Each cell's step = enable & AND of lower carries/borrows, gated off at the limit when WRAP=0.
- The top holds the rollover register, load clamping and at_limit.

Test Plan:
- DIGITS=2, WRAP=1: reset, then enable/up=1 for 100 cycles → bcd steps 00,01..09,10..99,00; at 99 at_limit=1; rollover=1 for exactly the cycle after 99→00.
- DIGITS=2: load 0x39, then up=1 for one cycle → 0x40 (carry across decades). Load 0x40, up=0 for one cycle → 0x39 (borrow).
- DIGITS=2, WRAP=0: load 0x01, up=0, enable for 3 cycles → 00, 00, 00; rollover high on the 2nd and 3rd cycles; bcd never 0x99.
- Priority: with bcd=0x55, assert load=1 (load_value=0x12), clear=1, enable=1 together → 00. Then reset with load → 00. Then load alone with load_value=0xAF → 0x99 (clamped).
- Mid-count: at 0x57 with enable held, toggle up each cycle → 58, 57, 58. Deassert enable → holds 58, rollover=0.
- DIGITS=4, WRAP=1: load 0x9999, up=1 step → 0x0000 with rollover pulse. up=0 step → 0x9999 with rollover pulse.
